// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled 8N1 deserialiser with a single-cycle done strobe
// and a framing-error flag. The shared baud tick source paces all counters.
module uart_receiver #(
    parameter int NB_DATA = 8,
    parameter int N_TICKS = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_signal_tick,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_error
);

    localparam int NB_BITS = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_BITS-1:0] LAST_BIT       = NB_BITS'(NB_DATA - 1);
    localparam logic [3:0]         MID_START_TICK = 4'd7;
    localparam logic [3:0]         LAST_DATA_TICK = 4'd15;
    localparam logic [3:0]         LAST_STOP_TICK = 4'(N_TICKS - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    state_t               state, state_next;
    logic [3:0]           sticks, sticks_next;
    logic [NB_BITS-1:0]   nbits, nbits_next;
    logic [NB_DATA-1:0]   buffer, buffer_next;
    logic [NB_DATA-1:0]   rx_data_next;
    logic                 rx_done_next;
    logic                 frame_error_next;
    logic [1:0]           reset_sync;
    logic                 reset_n;
    logic                 rx_meta;
    logic                 rx_s;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            reset_sync <= 2'b00;
        end else begin
            reset_sync <= {reset_sync[0], 1'b1};
        end
    end

    assign reset_n = reset_sync[1];

    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sticks        <= '0;
            nbits         <= '0;
            buffer        <= '0;
            o_rx_data     <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            state         <= state_next;
            sticks        <= sticks_next;
            nbits         <= nbits_next;
            buffer        <= buffer_next;
            o_rx_data     <= rx_data_next;
            o_rx_done     <= rx_done_next;
            o_frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        sticks_next      = sticks;
        nbits_next       = nbits;
        buffer_next      = buffer;
        rx_data_next     = o_rx_data;
        rx_done_next     = 1'b0;
        frame_error_next = o_frame_error;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next  = START;
                    sticks_next = '0;
                end
            end
            // Half a bit into the start bit: confirm it is still low, else treat as a glitch.
            START: begin
                if (i_signal_tick) begin
                    if (sticks == MID_START_TICK) begin
                        if (!rx_s) begin
                            state_next  = DATA;
                            sticks_next = '0;
                            nbits_next  = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        sticks_next = sticks + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_signal_tick) begin
                    if (sticks == LAST_DATA_TICK) begin
                        buffer_next = {rx_s, buffer[NB_DATA-1:1]};
                        sticks_next = '0;
                        if (nbits == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            nbits_next = nbits + 1'b1;
                        end
                    end else begin
                        sticks_next = sticks + 4'd1;
                    end
                end
            end
            STOP: begin
                if (i_signal_tick) begin
                    if (sticks == LAST_STOP_TICK) begin
                        state_next       = IDLE;
                        rx_data_next     = buffer;
                        frame_error_next = ~rx_s;
                        rx_done_next     = 1'b1;
                    end else begin
                        sticks_next = sticks + 4'd1;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                sticks_next = '0;
                nbits_next  = '0;
            end
        endcase
    end

endmodule
